// File: rtl/scu_pkg.sv
// Shared SCU ISA definitions: opcodes, ALU select codes and opcode predicates.
package scu_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [3:0] alu_sel_t;

  localparam opcode_t OP_NOP  = 4'b0000;
  localparam opcode_t OP_ST   = 4'b0011;
  localparam opcode_t OP_ADD  = 4'b0100;
  localparam opcode_t OP_INC  = 4'b0101;
  localparam opcode_t OP_NEG  = 4'b0110;
  localparam opcode_t OP_SUB  = 4'b0111;
  localparam opcode_t OP_J    = 4'b1000;
  localparam opcode_t OP_BRZ  = 4'b1001;
  localparam opcode_t OP_JM   = 4'b1010;
  localparam opcode_t OP_BRN  = 4'b1011;
  localparam opcode_t OP_LD   = 4'b1110;
  localparam opcode_t OP_SVPC = 4'b1111;

  localparam alu_sel_t SEL_NONE = 4'b0000;
  localparam alu_sel_t SEL_ADD  = 4'b0001;
  localparam alu_sel_t SEL_NEG  = 4'b0010;
  localparam alu_sel_t SEL_SUB  = 4'b0011;
  localparam alu_sel_t SEL_PASS = 4'b0100;

  // Opcodes whose ALU N/Z result becomes architectural flag state.
  function automatic logic is_flag_op(input opcode_t op);
    logic r;
    case (op)
      OP_ADD, OP_INC, OP_NEG, OP_SUB: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Control-transfer opcodes resolved in EX.
  function automatic logic is_branch(input opcode_t op);
    logic r;
    case (op)
      OP_J, OP_JM, OP_BRZ, OP_BRN: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_flag_ctrl_if.sv
// ID/EX/ALU signal bundle between the pipeline and the EX control block.
interface alu_flag_ctrl_if;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [3:0] alu_sel;
  logic       alu_n;
  logic       alu_z;
  logic       flag_n;
  logic       flag_z;
  logic       branch_taken;
  logic       flush;

  // Pipeline / ALU side: supplies instructions and ALU flags.
  modport master (
    output id_valid, id_opcode, alu_n, alu_z,
    input  ex_valid, ex_opcode, alu_sel, flag_n, flag_z, branch_taken, flush
  );

  // EX control block side.
  modport slave (
    input  id_valid, id_opcode, alu_n, alu_z,
    output ex_valid, ex_opcode, alu_sel, flag_n, flag_z, branch_taken, flush
  );
endinterface

// File: rtl/alu_flag_ctrl_alu_sel_decode.sv
// Pure-combinational opcode -> ALU select map; an invalid slot selects nothing.
module alu_sel_decode
  import scu_pkg::*;
(
  input  logic     valid,
  input  opcode_t  opcode,
  output alu_sel_t sel
);

  // Map the EX opcode to the ALU operation, forcing SEL_NONE for bubbles.
  always_comb begin
    sel = SEL_NONE;
    if (valid) begin
      case (opcode)
        OP_ADD, OP_INC, OP_LD, OP_ST, OP_SVPC: sel = SEL_ADD;
        OP_NEG:                                sel = SEL_NEG;
        OP_SUB:                                sel = SEL_SUB;
        OP_J, OP_JM, OP_BRZ, OP_BRN:           sel = SEL_PASS;
        default:                               sel = SEL_NONE;
      endcase
    end else begin
      sel = SEL_NONE;
    end
  end

endmodule

// File: rtl/alu_flag_ctrl.sv
// EX-stage control: EX register, ALU select, N/Z flag register,
// branch resolution and the post-branch squash counter.
module alu_flag_ctrl
  import scu_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  alu_flag_ctrl_if.slave bus
);

  localparam logic [1:0] SQ_RELOAD = 2'(FLUSH_DEPTH - 1);

  logic       ex_valid_q, ex_valid_d;
  opcode_t    ex_opcode_q, ex_opcode_d;
  logic       flag_n_q, flag_n_d;
  logic       flag_z_q, flag_z_d;
  logic [1:0] sq_cnt_q, sq_cnt_d;
  logic       branch_taken_s;
  alu_sel_t   alu_sel_s;

  alu_sel_decode u_sel_decode (
    .valid  (ex_valid_q),
    .opcode (ex_opcode_q),
    .sel    (alu_sel_s)
  );

  // Resolve the EX branch against the registered flags (no live-ALU bypass).
  always_comb begin
    branch_taken_s = 1'b0;
    if (ex_valid_q && is_branch(ex_opcode_q)) begin
      case (ex_opcode_q)
        OP_J, OP_JM: branch_taken_s = 1'b1;
        OP_BRZ:      branch_taken_s = flag_z_q;
        OP_BRN:      branch_taken_s = flag_n_q;
        default:     branch_taken_s = 1'b0;
      endcase
    end else begin
      branch_taken_s = 1'b0;
    end
  end

  // Advance the EX slot, or insert bubbles while a taken branch drains.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    sq_cnt_d    = sq_cnt_q;
    if (branch_taken_s) begin
      ex_valid_d = 1'b0;
      sq_cnt_d   = SQ_RELOAD;
    end else if (sq_cnt_q != 2'd0) begin
      ex_valid_d = 1'b0;
      sq_cnt_d   = sq_cnt_q - 2'd1;
    end else begin
      ex_valid_d  = bus.id_valid;
      ex_opcode_d = bus.id_opcode;
    end
  end

  // Capture ALU N/Z only for live arithmetic ops; everything else holds.
  always_comb begin
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (ex_valid_q && is_flag_op(ex_opcode_q)) begin
      flag_n_d = bus.alu_n;
      flag_z_d = bus.alu_z;
    end else begin
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
    end
  end

  // State registers; reset clears everything at once, including a flush in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= OP_NOP;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      sq_cnt_q    <= 2'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      sq_cnt_q    <= sq_cnt_d;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_opcode    = ex_opcode_q;
  assign bus.alu_sel      = alu_sel_s;
  assign bus.flag_n       = flag_n_q;
  assign bus.flag_z       = flag_z_q;
  assign bus.branch_taken = branch_taken_s;
  assign bus.flush        = branch_taken_s | (sq_cnt_q != 2'd0);

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Directed self-checking bench for alu_flag_ctrl (FLUSH_DEPTH 1, 2 and 3).
module tb_alu_flag_ctrl;
  import scu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic       alu_n;
  logic       alu_z;

  int n_cmp = 0;
  int n_err = 0;

  alu_flag_ctrl_if b1 ();
  alu_flag_ctrl_if b2 ();
  alu_flag_ctrl_if b3 ();

  assign b1.id_valid = id_valid;  assign b1.id_opcode = id_opcode;
  assign b1.alu_n    = alu_n;     assign b1.alu_z     = alu_z;
  assign b2.id_valid = id_valid;  assign b2.id_opcode = id_opcode;
  assign b2.alu_n    = alu_n;     assign b2.alu_z     = alu_z;
  assign b3.id_valid = id_valid;  assign b3.id_opcode = id_opcode;
  assign b3.alu_n    = alu_n;     assign b3.alu_z     = alu_z;

  alu_flag_ctrl #(.FLUSH_DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_flag_ctrl #(.FLUSH_DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  alu_flag_ctrl #(.FLUSH_DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Check the main FLUSH_DEPTH=2 instance: valid, sel, {n,z}, taken, flush.
  task automatic chk2(input string tag, input logic v, input logic [3:0] sel,
                      input logic n, input logic z, input logic bt, input logic fl);
    chk({tag, "_valid"}, {3'b000, b2.ex_valid}, {3'b000, v});
    chk({tag, "_sel"},   b2.alu_sel, sel);
    chk({tag, "_flags"}, {2'b00, b2.flag_n, b2.flag_z}, {2'b00, n, z});
    chk({tag, "_taken"}, {3'b000, b2.branch_taken}, {3'b000, bt});
    chk({tag, "_flush"}, {3'b000, b2.flush}, {3'b000, fl});
  endtask

  initial begin
    logic [3:0] fl1, fl2, fl3, dr1, dr2, dr3;
    rst = 1'b1; id_valid = 1'b0; id_opcode = OP_NOP; alu_n = 1'b0; alu_z = 1'b0;
    repeat (2) tick();
    chk2("reset", 1'b0, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_op", b2.ex_opcode, 4'b0000);
    rst = 1'b0;

    // ADD then SUB: select and flag capture one cycle after each op
    id_valid = 1'b1; id_opcode = OP_ADD;
    tick(); chk2("add", 1'b1, SEL_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b0; alu_z = 1'b1; id_opcode = OP_SUB;
    tick(); chk2("sub", 1'b1, SEL_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
    alu_n = 1'b1; alu_z = 1'b0; id_opcode = OP_ADD;
    tick(); chk2("add2", 1'b1, SEL_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b0; alu_z = 1'b1; id_opcode = OP_BRZ;

    // BRZ sees the ADD's Z=1: taken, flush 2 cycles, two slots dropped
    tick(); chk2("brz_t", 1'b1, SEL_PASS, 1'b0, 1'b1, 1'b1, 1'b1);
    alu_n = 1'b1; alu_z = 1'b1; id_opcode = OP_ADD;
    tick(); chk2("brz_sq1", 1'b0, SEL_NONE, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); chk2("brz_sq2", 1'b0, SEL_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    id_opcode = OP_INC;
    tick(); chk2("inc", 1'b1, SEL_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    alu_n = 1'b0; alu_z = 1'b0; id_opcode = OP_BRZ;

    // BRZ with Z=0: not taken, next instruction proceeds
    tick(); chk2("brz_nt", 1'b1, SEL_PASS, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b1; alu_z = 1'b1; id_opcode = OP_ADD;
    tick(); chk2("brz_nt_next", 1'b1, SEL_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b1; alu_z = 1'b0; id_opcode = OP_LD;

    // LD between ADD and BRN leaves N=1; BRN taken
    tick(); chk2("ld", 1'b1, SEL_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b0; alu_z = 1'b1; id_opcode = OP_BRN;
    tick(); chk2("brn_t", 1'b1, SEL_PASS, 1'b1, 1'b0, 1'b1, 1'b1);
    id_opcode = OP_NOP;
    tick(); chk2("brn_sq1", 1'b0, SEL_NONE, 1'b1, 1'b0, 1'b0, 1'b1);
    id_opcode = OP_SUB;
    tick(); chk2("brn_sq2", 1'b0, SEL_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk2("sub0", 1'b1, SEL_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b0; alu_z = 1'b0; id_opcode = OP_J;

    // J with flags 0 is taken; NEG behind it is squashed and writes nothing
    tick(); chk2("j", 1'b1, SEL_PASS, 1'b0, 1'b0, 1'b1, 1'b1);
    alu_n = 1'b0; alu_z = 1'b1; id_opcode = OP_NEG;
    tick(); chk2("neg_sq1", 1'b0, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    alu_n = 1'b1; alu_z = 1'b1;
    tick(); chk2("neg_sq2", 1'b0, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    id_opcode = 4'b0001;

    // Undefined opcode behaves as NOP
    tick(); chk2("undef", 1'b1, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_n = 1'b1; alu_z = 1'b1; id_valid = 1'b0;
    tick(); chk2("undef_after", 1'b0, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-flush clears everything immediately
    alu_n = 1'b0; alu_z = 1'b0; id_valid = 1'b1; id_opcode = OP_J;
    tick(); chk2("j_pre_rst", 1'b1, SEL_PASS, 1'b0, 1'b0, 1'b1, 1'b1);
    id_opcode = OP_ADD;
    #2 rst = 1'b1;
    #1 chk2("rst_mid", 1'b0, SEL_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_op", b2.ex_opcode, 4'b0000);
    #1 rst = 1'b0;
    tick(); chk2("rst_release", 1'b1, SEL_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_release_op", b2.ex_opcode, OP_ADD);

    // Flush-depth sweep: count flush cycles and dropped slots per instance
    id_opcode = OP_J;
    tick();
    fl1 = {3'b000, b1.flush}; fl2 = {3'b000, b2.flush}; fl3 = {3'b000, b3.flush};
    dr1 = 4'd0; dr2 = 4'd0; dr3 = 4'd0;
    id_opcode = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      tick();
      fl1 = fl1 + {3'b000, b1.flush}; dr1 = dr1 + {3'b000, ~b1.ex_valid};
      fl2 = fl2 + {3'b000, b2.flush}; dr2 = dr2 + {3'b000, ~b2.ex_valid};
      fl3 = fl3 + {3'b000, b3.flush}; dr3 = dr3 + {3'b000, ~b3.ex_valid};
    end
    chk("d1_flush", fl1, 4'd1);  chk("d1_drop", dr1, 4'd1);
    chk("d2_flush", fl2, 4'd2);  chk("d2_drop", dr2, 4'd2);
    chk("d3_flush", fl3, 4'd3);  chk("d3_drop", dr3, 4'd3);
    chk("d3_final_valid", {3'b000, b3.ex_valid}, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_flag_ctrl.md
# alu_flag_ctrl

EX-stage control block for the SCU ISA pipeline: drives the ALU from the other side of its select/flag interface. It registers the decoded instruction from ID, produces the 4-bit ALU select, and captures the ALU's N/Z outputs into an architectural flag register. It resolves BRZ/BRN/J/JM in EX and squashes the younger in-flight instructions after a taken branch.

## Interface

**Parameters**
- `FLUSH_DEPTH`, default 2: number of younger instructions squashed per taken branch (range 1–3).

**Ports**
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_opcode` in 4: ID-stage opcode.
- `ex_valid` out 1: EX register holds a live instruction.
- `ex_opcode` out 4: registered opcode.
- `alu_sel` out 4: ALU select, decoded from `ex_opcode`.
- `alu_n` in 1, `alu_z` in 1: ALU flag outputs for the current EX operation.
- `flag_n` out 1, `flag_z` out 1: architectural flag register.
- `branch_taken` out 1: EX instruction redirects PC this cycle.
- `flush` out 1: younger stages must be invalidated this cycle.

## Operation

- **Opcodes:** NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111. All other values are treated as NOP.
- **`alu_sel` (combinational from `ex_opcode`):**
  - ADD, INC, LD, ST, SVPC → 0001 (add).
  - NEG → 0010.
  - SUB → 0011.
  - J, JM, BRZ, BRN → 0100 (pass).
  - NOP, undefined, or `ex_valid`=0 → 0000.
- **Flag update:** on a clock edge with `ex_valid`=1 and opcode in {ADD, INC, NEG, SUB}, `flag_n` ← `alu_n` and `flag_z` ← `alu_z`. Flags hold for every other opcode, including branches and memory ops.
- **Branch resolution** (combinational, gated by `ex_valid`):
  - J and JM are always taken.
  - BRZ is taken iff `flag_z`=1.
  - BRN is taken iff `flag_n`=1.
  - Evaluation uses the flag register value, not the live `alu_n`/`alu_z`.
- **Squash counter** `sq_cnt`, width 2:
  - On an edge with `branch_taken`=1: `ex_valid` ← 0 and `sq_cnt` ← `FLUSH_DEPTH`−1.
  - Otherwise, on an edge with `sq_cnt`≠0: `ex_valid` ← 0 and `sq_cnt` decrements.
  - Otherwise: `ex_valid` ← `id_valid` and `ex_opcode` ← `id_opcode`.
- **`flush`** = `branch_taken` | (`sq_cnt`≠0).

## Timing

- **Reset values:**
  - `ex_valid`=0, `ex_opcode`=0000, `flag_n`=0, `flag_z`=0, `sq_cnt`=0.
  - Hence `alu_sel`=0000, `branch_taken`=0, `flush`=0.
- **Latency:**
  - ID → EX is 1 cycle.
  - A flag-writing op in EX at cycle t is visible on `flag_*` from t+1.
  - A BRZ/BRN directly following an ADD therefore sees the ADD's flags. No bypass is needed.
- **Branch at cycle t:**
  - `branch_taken` and `flush` are high in cycle t.
  - For `FLUSH_DEPTH`=2, `flush` is also high in t+1, and `ex_valid`=0 in t+1 and t+2.
  - The first fetched target instruction reaches EX at t+3.
- **Simultaneous events:** a branch cannot be in EX while `sq_cnt`≠0, because EX is invalid then. No priority rule is needed.
- **Squashed slots** never update the flags.
- **Reset mid-flush** clears `sq_cnt` and `ex_valid` immediately, asynchronously.
- **Undefined opcodes** are treated as NOP: no flag write, no branch.

## Structure

- Shared package `scu_pkg`:
  - Opcode constants.
  - ALU select constants (SEL_NONE 0000, SEL_ADD 0001, SEL_NEG 0010, SEL_SUB 0011, SEL_PASS 0100).
  - Predicate functions `is_flag_op` and `is_branch`.
- One natural sub-module: `alu_sel_decode`, a pure-combinational opcode→select map reused by the hazard unit.
- The EX register, flag register and squash counter stay in the top level.

## Test plan

- **Reset:** assert `rst` mid-cycle with `id_valid`=1 → all outputs 0 immediately; first edge after release captures ID.
- **Flag capture:** ADD with `alu_n`=0, `alu_z`=1, then SUB with `alu_n`=1, `alu_z`=0 → `alu_sel` 0001 then 0011; flags (0,1) then (1,0), each one cycle after the op.
- **BRZ on flags from the previous ADD:**
  - ADD (`alu_z`=1) then BRZ → `branch_taken`=1 in the BRZ cycle, `flush` high 2 cycles, next 2 `id_valid` instructions dropped.
  - Repeat with `alu_z`=0 → not taken, no flush.
- **BRN and J:**
  - BRN with `flag_n`=1 → taken.
  - J with flags 0 → taken, `alu_sel`=0100.
  - LD between ADD and BRN leaves the flags unchanged.
- **Squashed flag op:** NEG in the ID slot behind a taken J, with `alu_z`=1 → `flag_z` unchanged.
- **Parameter sweep:** `FLUSH_DEPTH`=1 and 3 → exactly 1 and 3 dropped slots; undefined opcode 0001 → `alu_sel`=0000, no flag or branch effect.
